// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: expands a 128-bit master key into 32 round keys, one per cycle.
// Optional reverse-readout store is enabled with `define SM4_KEY_RKSTORE_EN.
module sm4_key_expand #(
  parameter logic [31:0] FK0 = 32'hA3B1BAC6,
  parameter logic [31:0] FK1 = 32'h56AA3350,
  parameter logic [31:0] FK2 = 32'h677D9197,
  parameter logic [31:0] FK3 = 32'hB27022DC
) (
  input  logic         clk_sys,
  input  logic         rst_sys_n,
  input  logic         key_start,
  input  logic [127:0] key_in,
  output logic         key_busy,
  output logic [4:0]   sm4_round_cnt,
  input  logic [31:0]  sm4_key_cki,
  output logic         rk_valid,
  output logic [4:0]   rk_idx,
  output logic [31:0]  rk_out,
  output logic         key_done,
  input  logic [4:0]   rk_rd_addr,
  output logic [31:0]  rk_rd_data,
  output logic         rk_store_vld
);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;

  state_e      state_q;
  logic [31:0] k0_q, k1_q, k2_q, k3_q;
  logic [4:0]  r_q;
  logic        busy_q, valid_q, done_q;
  logic [4:0]  cnt_q, idx_q;
  logic [31:0] rk_q;
  logic [31:0] t_d, b_d, rk_d;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Round function T' of the key schedule, fed by the CK word the ROM returns this cycle.
  always_comb begin
    t_d  = k1_q ^ k2_q ^ k3_q ^ sm4_key_cki;
    b_d  = {SBOX[t_d[31:24]], SBOX[t_d[23:16]], SBOX[t_d[15:8]], SBOX[t_d[7:0]]};
    rk_d = k0_q ^ b_d ^ rotl(b_d, 13) ^ rotl(b_d, 23);
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= IDLE;
      k0_q    <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rk_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (key_start) begin
            k0_q    <= key_in[127:96] ^ FK0;
            k1_q    <= key_in[95:64]  ^ FK1;
            k2_q    <= key_in[63:32]  ^ FK2;
            k3_q    <= key_in[31:0]   ^ FK3;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= PRIME;
          end
        end
        PRIME: begin
          cnt_q   <= 5'd1;
          r_q     <= '0;
          state_q <= RUN;
        end
        RUN: begin
          rk_q    <= rk_d;
          idx_q   <= r_q;
          valid_q <= 1'b1;
          k0_q    <= k1_q;
          k1_q    <= k2_q;
          k2_q    <= k3_q;
          k3_q    <= rk_d;
          // The ROM runs two rounds ahead; past round 30 there is nothing left to fetch.
          cnt_q   <= (r_q >= 5'd30) ? 5'd0 : r_q + 5'd2;
          r_q     <= r_q + 5'd1;
          if (r_q == 5'd31) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_busy      = busy_q;
  assign sm4_round_cnt = cnt_q;
  assign rk_valid      = valid_q;
  assign rk_idx        = idx_q;
  assign rk_out        = rk_q;
  assign key_done      = done_q;

`ifdef SM4_KEY_RKSTORE_EN
  logic [31:0] store_q [32];
  logic [31:0] rd_data_q;
  logic        store_vld_q;

  // Written alongside rk_out so the schedule is complete in the same cycle key_done rises.
  always_ff @(posedge clk_sys) begin
    if (state_q == RUN) store_q[r_q] <= rk_d;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rd_data_q   <= '0;
      store_vld_q <= 1'b0;
    end else begin
      rd_data_q <= store_q[rk_rd_addr];
      if (state_q == IDLE && key_start) store_vld_q <= 1'b0;
      else if (state_q == RUN && r_q == 5'd31) store_vld_q <= 1'b1;
    end
  end

  assign rk_rd_data   = rd_data_q;
  assign rk_store_vld = store_vld_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rk_rd_addr;
  assign rk_rd_data     = '0;
  assign rk_store_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench for sm4_key_expand with a behavioural CK ROM and an independent key-schedule model.
module tb_sm4_key_expand;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  localparam logic [127:0] MK_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] MK_ALT = 128'hDEADBEEF0BADF00DCAFEBABE13572468;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_start = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_busy;
  logic [4:0]   round_cnt;
  logic [31:0]  cki;
  logic         rk_valid;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_out;
  logic         key_done;
  logic [4:0]   rd_addr = '0;
  logic [31:0]  rd_data;
  logic         store_vld;

  logic [31:0]  exp_rk [32];
  int           checks = 0;
  int           errors = 0;

  sm4_key_expand dut (
    .clk_sys      (clk),
    .rst_sys_n    (rst_n),
    .key_start    (key_start),
    .key_in       (key_in),
    .key_busy     (key_busy),
    .sm4_round_cnt(round_cnt),
    .sm4_key_cki  (cki),
    .rk_valid     (rk_valid),
    .rk_idx       (rk_idx),
    .rk_out       (rk_out),
    .key_done     (key_done),
    .rk_rd_addr   (rd_addr),
    .rk_rd_data   (rd_data),
    .rk_store_vld (store_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[31 - 8*j -: 8] = 8'((4 * int'(i) + j) * 7);
    return w;
  endfunction

  // Registered CK ROM: the word for the index seen at an edge appears after that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cki <= '0;
    else cki <= ck_word(round_cnt);
  end

  task automatic compute_ref(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] t, b;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(5'(i));
      b = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
      k[i+4] = k[i] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
      exp_rk[i] = k[i+4];
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after edge S with key_start already dropped.
  task automatic start_key(input logic [127:0] mk);
    key_start = 1'b1;
    key_in    = mk;
    tick();
    key_start = 1'b0;
    key_in    = '1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", key_busy); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", rk_valid); end
    checks++; if (key_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b expected 0", key_done); end
    checks++; if (store_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_store_vld: got %b expected 0", store_vld); end
    checks++; if (round_cnt !== 5'd0) begin errors++; $display("[TB] FAIL rst_round_cnt: got %0d expected 0", round_cnt); end
    checks++; if (rk_idx !== 5'd0) begin errors++; $display("[TB] FAIL rst_idx: got %0d expected 0", rk_idx); end
    checks++; if (rk_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_rk_out: got %h expected 0", rk_out); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd_data: got %h expected 0", rd_data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_standard;
    compute_ref(MK_STD);
    start_key(MK_STD);
    for (int c = 0; c <= 34; c++) begin
      checks++; if (key_busy !== (c <= 33)) begin errors++; $display("[TB] FAIL std_busy@%0d: got %b expected %b", c, key_busy, c <= 33); end
      if (c <= 31) begin
        checks++; if (round_cnt !== 5'(c)) begin errors++; $display("[TB] FAIL std_round_cnt@%0d: got %0d expected %0d", c, round_cnt, c); end
      end
      checks++; if (rk_valid !== (c >= 2 && c <= 33)) begin errors++; $display("[TB] FAIL std_valid@%0d: got %b", c, rk_valid); end
      checks++; if (key_done !== (c == 33)) begin errors++; $display("[TB] FAIL std_done@%0d: got %b", c, key_done); end
      if (c >= 2 && c <= 33) begin
        checks++; if (rk_idx !== 5'(c - 2)) begin errors++; $display("[TB] FAIL std_idx@%0d: got %0d expected %0d", c, rk_idx, c - 2); end
        checks++; if (rk_out !== exp_rk[c-2]) begin errors++; $display("[TB] FAIL std_rk[%0d]: got %h expected %h", c - 2, rk_out, exp_rk[c-2]); end
      end
      if (c == 2) begin
        checks++; if (rk_out !== 32'hF12186F9) begin errors++; $display("[TB] FAIL std_rk0_vec: got %h expected F12186F9", rk_out); end
      end
      if (c == 3) begin
        checks++; if (rk_out !== 32'h41662B61) begin errors++; $display("[TB] FAIL std_rk1_vec: got %h expected 41662B61", rk_out); end
      end
      if (c == 33) begin
        checks++; if (rk_out !== 32'h9124A012) begin errors++; $display("[TB] FAIL std_rk31_vec: got %h expected 9124A012", rk_out); end
      end
      if (c < 34) tick();
    end
  endtask

  task automatic test_start_ignored;
    compute_ref(MK_STD);
    start_key(MK_STD);
    for (int c = 0; c <= 34; c++) begin
      if (c >= 2 && c <= 33) begin
        checks++; if (rk_out !== exp_rk[c-2]) begin errors++; $display("[TB] FAIL ign_rk[%0d]: got %h expected %h", c - 2, rk_out, exp_rk[c-2]); end
      end
      checks++; if (key_done !== (c == 33)) begin errors++; $display("[TB] FAIL ign_done@%0d: got %b", c, key_done); end
      // Pulses land on edges S+10 (mid-run) and S+33 (coincident with key_done).
      key_start = (c == 9 || c == 32);
      key_in    = MK_ALT;
      if (c < 34) tick();
    end
    key_start = 1'b0;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_busy_after: got %b expected 0", key_busy); end
    checks++; if (round_cnt !== 5'd0) begin errors++; $display("[TB] FAIL ign_cnt_after: got %0d expected 0", round_cnt); end
  endtask

  task automatic test_back_to_back;
    start_key(MK_STD);
    for (int c = 0; c < 33; c++) tick();
    checks++; if (key_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done: got %b expected 1", key_done); end
    compute_ref(128'h0);
    start_key(128'h0);
    for (int c = 0; c <= 34; c++) begin
      checks++; if (key_busy !== (c <= 33)) begin errors++; $display("[TB] FAIL b2b_busy@%0d: got %b", c, key_busy); end
      if (c >= 2 && c <= 33) begin
        checks++; if (rk_idx !== 5'(c - 2)) begin errors++; $display("[TB] FAIL b2b_idx@%0d: got %0d expected %0d", c, rk_idx, c - 2); end
        checks++; if (rk_out !== exp_rk[c-2]) begin errors++; $display("[TB] FAIL b2b_rk[%0d]: got %h expected %h", c - 2, rk_out, exp_rk[c-2]); end
      end
      checks++; if (key_done !== (c == 33)) begin errors++; $display("[TB] FAIL b2b_done@%0d: got %b", c, key_done); end
      if (c < 34) tick();
    end
  endtask

  task automatic test_reset_mid;
    compute_ref(MK_STD);
    start_key(MK_STD);
    for (int c = 0; c < 15; c++) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (key_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", key_busy); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", rk_valid); end
    checks++; if (round_cnt !== 5'd0) begin errors++; $display("[TB] FAIL mid_round_cnt: got %0d expected 0", round_cnt); end
    checks++; if (rk_idx !== 5'd0) begin errors++; $display("[TB] FAIL mid_idx: got %0d expected 0", rk_idx); end
    checks++; if (rk_out !== 32'h0) begin errors++; $display("[TB] FAIL mid_rk_out: got %h expected 0", rk_out); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_rd_data: got %h expected 0", rd_data); end
    checks++; if (store_vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_store_vld: got %b expected 0", store_vld); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (key_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done@%0d: got %b expected 0", c, key_done); end
    end
    rst_n = 1'b1;
    tick();
    start_key(MK_STD);
    for (int c = 0; c <= 33; c++) begin
      if (c >= 2) begin
        checks++; if (rk_out !== exp_rk[c-2]) begin errors++; $display("[TB] FAIL mid_rk[%0d]: got %h expected %h", c - 2, rk_out, exp_rk[c-2]); end
      end
      checks++; if (key_done !== (c == 33)) begin errors++; $display("[TB] FAIL mid_redo_done@%0d: got %b", c, key_done); end
      tick();
    end
  endtask

  task automatic test_store;
    compute_ref(MK_STD);
`ifdef SM4_KEY_RKSTORE_EN
    checks++; if (store_vld !== 1'b1) begin errors++; $display("[TB] FAIL st_vld_before: got %b expected 1", store_vld); end
    start_key(MK_STD);
    checks++; if (store_vld !== 1'b0) begin errors++; $display("[TB] FAIL st_vld_cleared: got %b expected 0", store_vld); end
    for (int c = 0; c < 33; c++) tick();
    checks++; if (store_vld !== 1'b1) begin errors++; $display("[TB] FAIL st_vld_set: got %b expected 1", store_vld); end
    for (int a = 31; a >= 0; a--) begin
      rd_addr = 5'(a);
      tick();
      checks++; if (rd_data !== exp_rk[a]) begin errors++; $display("[TB] FAIL st_rd[%0d]: got %h expected %h", a, rd_data, exp_rk[a]); end
    end
`else
    start_key(MK_STD);
    for (int c = 0; c < 34; c++) tick();
    for (int a = 31; a >= 28; a--) begin
      rd_addr = 5'(a);
      tick();
      checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL st_rd_off[%0d]: got %h expected 0", a, rd_data); end
      checks++; if (store_vld !== 1'b0) begin errors++; $display("[TB] FAIL st_vld_off: got %b expected 0", store_vld); end
    end
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_standard();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
